// File: rtl/p3_port_arbiter_if.sv
// Request/grant and P3 register drive signals shared between the P3 arbiter
// (slave side) and its requesters/P3 register (master side).
interface p3_port_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic              done;
    logic              busy;
    logic [3:0]        p3_din;
    logic              p3_ld;

    modport master (
        output req, req_data,
        input  gnt, done, busy, p3_din, p3_ld
    );

    modport slave (
        input  req, req_data,
        output gnt, done, busy, p3_din, p3_ld
    );
endinterface

// File: rtl/p3_port_arbiter.sv
// Shares the 4-bit P3 output register among NREQ requesters: fixed LD window per grant,
// then one all-zero gap cycle. Define P3ARB_RR_EN for round-robin, else fixed priority.
module p3_port_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               CLK,
    input  logic               rst_n,
    p3_port_arbiter_if.slave   bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t          state_reg;
    logic [NREQ-1:0] gnt_reg;
    logic            done_reg;
    logic            busy_reg;
    logic [3:0]      p3_din_reg;   // doubles as the frozen data_q during HOLD
    logic            p3_ld_reg;
    logic [CW-1:0]   hold_cnt_reg;

    logic            req_any;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] win_onehot;
    logic [3:0]      win_data;
    logic [3:0]      req_nib [NREQ];

    assign req_any = |bus.req;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_nib[gi]    = bus.req_data[4*gi +: 4];
            assign win_onehot[gi] = (win_idx == PW'(gi));
        end
    endgenerate

    assign win_data = req_nib[win_idx];

`ifdef P3ARB_RR_EN
    logic [PW-1:0] rr_ptr_reg;
    logic [PW-1:0] rr_next;
    logic [PW:0]   cand;

    // Descending scan so the candidate closest to rr_ptr (upward, wrapping) wins last.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_reg} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ))
                cand = cand - (PW+1)'(NREQ);
            if (bus.req[cand[PW-1:0]])
                win_idx = cand[PW-1:0];
        end
    end

    assign rr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)
            rr_ptr_reg <= '0;
        else if (req_any && (state_reg != HOLD))
            rr_ptr_reg <= rr_next;
    end
`else
    always_comb begin
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[k])
                win_idx = PW'(k);
        end
    end
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            p3_din_reg   <= '0;
            p3_ld_reg    <= 1'b0;
            hold_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, GAP: begin
                    if (req_any) begin
                        state_reg    <= HOLD;
                        gnt_reg      <= win_onehot;
                        p3_din_reg   <= win_data;
                        p3_ld_reg    <= 1'b1;
                        busy_reg     <= 1'b1;
                        hold_cnt_reg <= CW'(1);
                    end else begin
                        state_reg    <= IDLE;
                        gnt_reg      <= '0;
                        p3_din_reg   <= '0;
                        p3_ld_reg    <= 1'b0;
                        busy_reg     <= 1'b0;
                        hold_cnt_reg <= '0;
                    end
                end
                HOLD: begin
                    // Requests and data are ignored until the window closes.
                    if (hold_cnt_reg == CW'(HOLD_CYCLES)) begin
                        state_reg    <= GAP;
                        gnt_reg      <= '0;
                        p3_din_reg   <= '0;
                        p3_ld_reg    <= 1'b0;
                        done_reg     <= 1'b1;
                        busy_reg     <= 1'b1;
                        hold_cnt_reg <= '0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    gnt_reg      <= '0;
                    p3_din_reg   <= '0;
                    p3_ld_reg    <= 1'b0;
                    busy_reg     <= 1'b0;
                    hold_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_reg;
    assign bus.done   = done_reg;
    assign bus.busy   = busy_reg;
    assign bus.p3_din = p3_din_reg;
    assign bus.p3_ld  = p3_ld_reg;
endmodule

// File: tb/tb_p3_port_arbiter.sv
// Bench for p3_port_arbiter: fixed vector table, directed corner sequences and random
// traffic checked against a per-cycle output schedule model.
module tb_p3_port_arbiter;
    localparam int NREQ = 4;
    localparam int HOLD = 4;

    logic CLK   = 1'b0;
    logic rst_n = 1'b0;

    p3_port_arbiter_if #(.NREQ(NREQ)) bus();

    p3_port_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic            ld;
        logic [3:0]      din;
        logic            done;
        logic            busy;
    } out_t;

    typedef struct packed {
        logic [NREQ-1:0]   req;
        logic [4*NREQ-1:0] data;
        out_t              exp;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: queue of expected outputs for upcoming cycles; empty means idle.
    out_t exp_q[$];
    int   model_ptr = 0;

    function automatic int pick(input logic [NREQ-1:0] r);
`ifdef P3ARB_RR_EN
        for (int k = 0; k < NREQ; k++)
            if (r[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
`else
        for (int i = 0; i < NREQ; i++)
            if (r[i]) return i;
`endif
        return -1;
    endfunction

    task automatic model_edge(input logic [NREQ-1:0] r, input logic [4*NREQ-1:0] d);
        bit   decide;
        int   w;
        out_t o;
        if (!rst_n) begin
            exp_q.delete();
            model_ptr = 0;
            return;
        end
        decide = (exp_q.size() == 0) || exp_q[0].done;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (decide && (|r)) begin
            w = pick(r);
            model_ptr = (w + 1) % NREQ;
            o.gnt  = NREQ'(1) << w;
            o.ld   = 1'b1;
            o.din  = d[4*w +: 4];
            o.done = 1'b0;
            o.busy = 1'b1;
            for (int h = 0; h < HOLD; h++) exp_q.push_back(o);
            exp_q.push_back(out_t'{gnt: '0, ld: 1'b0, din: 4'h0, done: 1'b1, busy: 1'b1});
        end
    endtask

    function automatic out_t model_out();
        if (exp_q.size() > 0) return exp_q[0];
        return '0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input out_t e);
        chk({tag, ".gnt"},  32'(bus.gnt),    32'(e.gnt));
        chk({tag, ".ld"},   32'(bus.p3_ld),  32'(e.ld));
        chk({tag, ".din"},  32'(bus.p3_din), 32'(e.din));
        chk({tag, ".done"}, 32'(bus.done),   32'(e.done));
        chk({tag, ".busy"}, 32'(bus.busy),   32'(e.busy));
    endtask

    // Called at a negedge: drive, advance one clock, compare against the model.
    task automatic cycle(input string tag, input logic [NREQ-1:0] r, input logic [4*NREQ-1:0] d);
        bus.req      = r;
        bus.req_data = d;
        @(posedge CLK);
        model_edge(r, d);
        @(negedge CLK);
        check_outs(tag, model_out());
        $display("%s req=%b gnt=%b ld=%b din=%h done=%b busy=%b",
                 tag, r, bus.gnt, bus.p3_ld, bus.p3_din, bus.done, bus.busy);
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] g);
        for (int i = 0; i < NREQ; i++) if (g[i]) return i;
        return 255;
    endfunction

    vec_t tbl[7];
    int   owners[$];
    int   exp_owner;
    logic prev_ld;

    initial begin
        // Single-requester window with data/REQ changes mid-window; non-winner nibbles are F.
        tbl[0] = '{req: 4'b0001, data: 16'hFFFA, exp: '{gnt: 4'b0001, ld: 1, din: 4'hA, done: 0, busy: 1}};
        tbl[1] = '{req: 4'b0000, data: 16'hFFF5, exp: '{gnt: 4'b0001, ld: 1, din: 4'hA, done: 0, busy: 1}};
        tbl[2] = '{req: 4'b0000, data: 16'hFFF5, exp: '{gnt: 4'b0001, ld: 1, din: 4'hA, done: 0, busy: 1}};
        tbl[3] = '{req: 4'b0000, data: 16'hFFF5, exp: '{gnt: 4'b0001, ld: 1, din: 4'hA, done: 0, busy: 1}};
        tbl[4] = '{req: 4'b0000, data: 16'hFFF5, exp: '{gnt: 4'b0000, ld: 0, din: 4'h0, done: 1, busy: 1}};
        tbl[5] = '{req: 4'b0000, data: 16'hFFF5, exp: '{gnt: 4'b0000, ld: 0, din: 4'h0, done: 0, busy: 0}};
        tbl[6] = '{req: 4'b0000, data: 16'hFFF5, exp: '{gnt: 4'b0000, ld: 0, din: 4'h0, done: 0, busy: 0}};

        bus.req      = '1;
        bus.req_data = 16'h1234;
        @(negedge CLK);

        // Held in reset with every requester active: outputs stay zero.
        for (int i = 0; i < 3; i++) cycle("rst_hold", 4'hF, 16'h9876);
        rst_n = 1'b1;
        bus.req = '0;

        for (int i = 0; i < 7; i++) begin
            bus.req      = tbl[i].req;
            bus.req_data = tbl[i].data;
            @(posedge CLK);
            model_edge(tbl[i].req, tbl[i].data);
            @(negedge CLK);
            check_outs($sformatf("tbl%0d", i), tbl[i].exp);
            $display("tbl%0d req=%b gnt=%b ld=%b din=%h done=%b busy=%b",
                     i, tbl[i].req, bus.gnt, bus.p3_ld, bus.p3_din, bus.done, bus.busy);
        end

        // All requesting continuously: record each window's owner.
        prev_ld = 1'b0;
        for (int i = 0; i < 5 * (HOLD + 1); i++) begin
            cycle("allreq", 4'hF, 16'h4321);
            if (bus.p3_ld && !prev_ld) owners.push_back(onehot_idx(bus.gnt));
            prev_ld = bus.p3_ld;
        end
        for (int i = 0; i < 5; i++) begin
`ifdef P3ARB_RR_EN
            exp_owner = i % NREQ;
`else
            exp_owner = 0;
`endif
            chk($sformatf("owner%0d", i), (i < owners.size()) ? 32'(owners[i]) : 32'hFF, 32'(exp_owner));
        end
        for (int i = 0; i < HOLD + 2; i++) cycle("drain", 4'h0, 16'h0);

        // Asynchronous reset in the second hold cycle.
        cycle("pre_rst", 4'b0100, 16'h0B00);
        cycle("pre_rst", 4'b0000, 16'h0000);
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", '0);
        model_edge(4'h0, 16'h0);
        cycle("in_rst", 4'hF, 16'h7654);
        rst_n = 1'b1;
        cycle("post_rst", 4'hF, 16'h7654);
        chk("post_rst_first_gnt", 32'(bus.gnt), 32'h1);
        chk("post_rst_din", 32'(bus.p3_din), 32'h4);
        for (int i = 0; i < HOLD + 2; i++) cycle("drain", 4'h0, 16'h0);

        // Request that appears only during the gap cycle is served immediately.
        cycle("gap_seq", 4'b0001, 16'h00C3);
        for (int i = 0; i < HOLD - 1; i++) cycle("gap_seq", 4'b0000, 16'h0000);
        cycle("gap_seq", 4'b0000, 16'h0000);
        chk("gap_done", 32'(bus.done), 32'h1);
        cycle("gap_req", 4'b0010, 16'h00D0);
        chk("gap_next_gnt", 32'(bus.gnt), 32'h2);
        chk("gap_next_ld", 32'(bus.p3_ld), 32'h1);
        chk("gap_next_din", 32'(bus.p3_din), 32'hD);
        for (int i = 0; i < HOLD + 2; i++) cycle("drain", 4'h0, 16'h0);

        // Random traffic: sparse and bursty requests with random data.
        for (int i = 0; i < 400; i++) begin
            logic [NREQ-1:0]   r;
            logic [4*NREQ-1:0] d;
            r = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
            d = (4*NREQ)'($urandom);
            cycle("rand", r, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
